// File: rtl/real_nearest_pkg.sv
// Shared types and elaboration helpers for real_nearest_addr: FSM states,
// address-width sizing and real-to-fixed conversion of coefficient tables.
package real_nearest_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Address width for an N-entry table, never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Round r * 2^-exponent half away from zero. The result is kept wide so the
  // caller can range-check it before narrowing to its word width.
  function automatic longint to_fixed(input real r, input int exponent);
    real scale;
    real scaled;
    scale = 1.0;
    if (exponent < 0) begin
      for (int k = 0; k < -exponent; k++) scale = scale * 2.0;
    end else begin
      for (int k = 0; k < exponent; k++) scale = scale / 2.0;
    end
    scaled = r * scale;
    if (scaled >= 0.0) return longint'($floor(scaled + 0.5));
    else               return -longint'($floor(-scaled + 0.5));
  endfunction

endpackage

// File: rtl/real_nearest_addr_if.sv
// Start/ready/done query bus of real_nearest_addr.
interface real_nearest_addr_if #(
  parameter int unsigned WIDTH  = 18,
  parameter int unsigned ADDR_W = 2
);
  logic                    start;
  logic signed [WIDTH-1:0] value_in;
  logic                    ready;
  logic                    done;
  logic [ADDR_W-1:0]       addr_out;

  modport master (output start, output value_in, input ready, input done, input addr_out);
  modport slave  (input start, input value_in, output ready, output done, output addr_out);
endinterface

// File: rtl/real_nearest_addr_abs_diff.sv
// real_abs_diff: combinational |a - b| of two signed words, widened by one bit
// so the magnitude never overflows.
module real_abs_diff #(
  parameter int unsigned WIDTH = 18
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic        [WIDTH:0]   diff
);
  logic [WIDTH:0] sub_c;

  always_comb begin
    sub_c = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    diff  = sub_c[WIDTH] ? ((~sub_c) + (WIDTH+1)'(1)) : sub_c;
  end
endmodule

// File: rtl/real_nearest_addr.sv
// Value-to-address inverse lookup: linear scan for the nearest constant coefficient.
// Optional REAL_NEAREST_EXACT_EXIT_EN ends the scan early on an exact match.
module real_nearest_addr
  import real_nearest_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned WIDTH    = 18,
  parameter int          EXPONENT = -12,
  parameter real         COEFFS [N] = '{1.2, 3.4, 5.6, 7.8}
) (
  input  logic               clk,
  input  logic               rst_n,
  real_nearest_addr_if.slave bus
);
  localparam int unsigned ADDR_W = addr_w(N);
  localparam int unsigned DIST_W = WIDTH + 1;
  localparam longint      FX_MAX = (longint'(1) <<< (WIDTH - 1)) - 1;
  localparam longint      FX_MIN = -(longint'(1) <<< (WIDTH - 1));

  logic signed [WIDTH-1:0] coef_fx [N];

  // Coefficient table, converted and range-checked at elaboration.
  for (genvar g = 0; g < N; g++) begin : g_coef
    localparam longint FX = to_fixed(COEFFS[g], EXPONENT);
    if (FX > FX_MAX || FX < FX_MIN) begin : g_range_err
      $error("real_nearest_addr: COEFFS[%0d] does not fit in %0d bits", g, WIDTH);
    end
    assign coef_fx[g] = WIDTH'(FX);
  end

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       idx_q, idx_d;
  logic [DIST_W-1:0]       best_dist_q, best_dist_d;
  logic [ADDR_W-1:0]       best_idx_q, best_idx_d;
  logic signed [WIDTH-1:0] value_q, value_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    done_q, done_d;
  logic                    ready_q, ready_d;
  logic [DIST_W-1:0]       dist_c;

  real_abs_diff #(.WIDTH(WIDTH)) u_abs_diff (
    .a    (value_q),
    .b    (coef_fx[idx_q]),
    .diff (dist_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      best_dist_q <= '0;
      best_idx_q  <= '0;
      value_q     <= '0;
      addr_q      <= '0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      best_dist_q <= best_dist_d;
      best_idx_q  <= best_idx_d;
      value_q     <= value_d;
      addr_q      <= addr_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
    end
  end

  always_comb begin
    logic              better;
    logic [ADDR_W-1:0] cand_idx;
    logic              finish;
    state_d     = state_q;
    idx_d       = idx_q;
    best_dist_d = best_dist_q;
    best_idx_d  = best_idx_q;
    value_d     = value_q;
    addr_d      = addr_q;
    done_d      = 1'b0;
    better      = 1'b0;
    cand_idx    = best_idx_q;
    finish      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          value_d     = bus.value_in;
          idx_d       = '0;
          best_dist_d = '1;
          best_idx_d  = '0;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        // Strict compare keeps the lowest index on ties.
        better   = (dist_c < best_dist_q);
        cand_idx = better ? idx_q : best_idx_q;
        if (better) begin
          best_dist_d = dist_c;
          best_idx_d  = idx_q;
        end
        finish = (idx_q == ADDR_W'(N - 1));
`ifdef REAL_NEAREST_EXACT_EXIT_EN
        if (dist_c == '0) finish = 1'b1;
`endif
        if (finish) begin
          addr_d  = cand_idx;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  assign bus.ready    = ready_q;
  assign bus.done     = done_q;
  assign bus.addr_out = addr_q;

endmodule
